// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3 / double dabble).
// One correct-and-shift iteration per clock, start/busy/done handshake,
// result and overflow flag held until the next conversion completes.
module bin2bcd_seq #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  ovf
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned BW = 4 * DIGITS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [WIDTH-1:0] bin_q, bin_d;       // binary shift register
    logic [BW-1:0]    acc_q, acc_d;       // BCD accumulator
    logic             sticky_q, sticky_d; // bits lost off the top digit
    logic [CW-1:0]    cnt_q, cnt_d;       // iterations remaining
    logic [BW-1:0]    bcd_q, bcd_d;       // published result
    logic             ovf_q, ovf_d;       // published overflow

    logic [BW-1:0]    acc_corr;           // accumulator after add-3 correction
    logic [BW-1:0]    acc_shift;          // corrected accumulator shifted left
    logic [WIDTH-1:0] bin_shift;          // binary register shifted left
    logic             carry_out;          // bit leaving the top digit this iteration

    // Add 3 to a digit that would become >= 10 after doubling.
    function automatic logic [3:0] adj3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    // Per-digit correction units followed by the combined left shift.
    always_comb begin
        acc_corr = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            acc_corr[4*i +: 4] = adj3(acc_q[4*i +: 4]);
        end
        carry_out = acc_corr[BW-1];
        acc_shift = {acc_corr[BW-2:0], bin_q[WIDTH-1]};
        bin_shift = {bin_q[WIDTH-2:0], 1'b0};
    end

    // Next-state and datapath update for the IDLE/CONV/DONE sequence.
    always_comb begin
        // NOTE: every target gets a default first so no path leaves a latch.
        state_d  = state_q;
        bin_d    = bin_q;
        acc_d    = acc_q;
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        bcd_d    = bcd_q;
        ovf_d    = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    bin_d    = bin_in;
                    acc_d    = '0;
                    sticky_d = 1'b0;
                    cnt_d    = CW'(WIDTH);
                    state_d  = S_CONV;
                end
            end
            S_CONV: begin
                acc_d    = acc_shift;
                bin_d    = bin_shift;
                sticky_d = sticky_q | carry_out;
                cnt_d    = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    bcd_d   = acc_shift;
                    ovf_d   = sticky_q | carry_out;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any conversion in flight.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments so every register sees pre-edge values.
        if (rst) begin
            state_q  <= S_IDLE;
            bin_q    <= '0;
            acc_q    <= '0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
            bcd_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bin_q    <= bin_d;
            acc_q    <= acc_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
            bcd_q    <= bcd_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy    = (state_q == S_CONV);
    assign done    = (state_q == S_DONE);
    assign bcd_out = bcd_q;
    assign ovf     = ovf_q;

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm.
- Controls a bank of per-digit add-3 correction units, one per BCD digit. It performs one adjust-and-shift iteration per clock.
- Sits between binary datapath results and the BCD display/decoder logic.
- Uses a start/busy/done handshake, so a single converter can serve a requester without any combinational loop.

Parameters:
- WIDTH, 8, bit width of the binary input. Also the number of iterations.
- DIGITS, 3, number of BCD output digits. Output width is 4*DIGITS.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to convert. Sampled only in IDLE.
- bin_in  input  WIDTH  binary operand. Captured on the accepting edge only.
- busy  output  1  high while a conversion is in progress (state CONV).
- done  output  1  one-cycle pulse when bcd_out/ovf hold a new result.
- bcd_out  output  4*DIGITS  packed BCD result. Digit 0 is in bits [3:0].
- ovf  output  1  result did not fit in DIGITS digits.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - busy=0, done=0, bcd_out=0, ovf=0.
  - Internal shift register and iteration counter are cleared.
  - Takes effect immediately, including mid-conversion. The conversion in progress is abandoned and no done pulse is produced.
- States: IDLE, CONV, DONE.
- IDLE:
  - If start=1 at edge E0: load bin_in into the binary shift register, clear the BCD accumulator and sticky overflow, set counter=WIDTH, go to CONV.
  - Otherwise remain in IDLE.
- CONV (busy=1), one iteration per edge:
  - (a) Each 4-bit accumulator digit d is replaced by d+3 (mod 16) if d>=5, otherwise left unchanged. All digits are corrected in parallel.
  - (b) The corrected {BCD accumulator, binary register} is shifted left by 1.
  - (c) The bit shifted out of the top digit is ORed into the sticky overflow.
  - (d) counter is decremented.
  - When the iteration with counter=1 completes, at edge E_WIDTH: bcd_out<=accumulator, ovf<=sticky, go to DONE.
- DONE: done=1, busy=0 for exactly one cycle. Return to IDLE at the next edge.
- Latency:
  - start sampled at E0.
  - done high in the cycle after E_WIDTH (WIDTH+1 edges after E0 counting E0 itself). For the default, done is visible in the 9th cycle after start.
- Result holding: bcd_out and ovf hold their value until the next conversion completes or reset. They are not cleared by start.
- start while busy or done: ignored, with no effect on the current conversion. bin_in changes after E0 are ignored.
- Back-to-back: start held high continuously is accepted at the first IDLE edge after DONE. Throughput is one conversion per WIDTH+2 cycles.
- Every digit of bcd_out is in the range 0..9 whenever ovf=0.

Test Plan:
- Reset, then bin_in=8'd0 with start pulse -> done after WIDTH+1 edges; bcd_out=12'h000, ovf=0; busy high for exactly 8 cycles.
- bin_in=8'd255 with start -> bcd_out=12'h255, ovf=0. Also bin_in=8'd99 -> 12'h099, and 8'd100 -> 12'h100.
- Drive start again and change bin_in to 8'd7 while busy during a 255 conversion -> result still 12'h255. Exactly one done pulse; next start is accepted only after returning to IDLE.
- Assert rst for 1 cycle at the 4th CONV cycle of a 128 conversion -> busy=0, done=0, bcd_out=0 immediately. No done pulse follows. A new start with 8'd42 then yields 12'h042.
- Parameter instance with WIDTH=8, DIGITS=2: bin_in=8'd100 -> ovf=1. bin_in=8'd99 -> bcd_out=8'h99, ovf=0.
- Exhaustive sweep of 0..255 with start held high -> each done pulse has bcd_out equal to the decimal digits of the input. Pulses are spaced exactly 10 cycles apart.
